// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind the CPU memory stage.
// Each accepted request waits LATENCY cycles, performs the access, then
// answers with a one-cycle ready pulse carrying registered read data.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  access;
    logic                  legal;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           old_word;

    // Address decode and access strobe for the captured request
    always_comb begin
        legal    = (addr_q[1:0] == 2'b00) && ((addr_q >> (ADDR_WIDTH + 2)) == 32'h0);
        idx      = addr_q[ADDR_WIDTH+1:2];
        access   = (state_q == WAIT) && (cnt_q == 3'd0);
        old_word = mem[idx];
        mem_we   = access && legal && we_q;
    end

    // State register plus all registered datapath/response state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (cnt_q == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and response data
    always_comb begin
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        if (state_q == IDLE && req) begin
            we_d    = we;
            addr_d  = addr;
            wstrb_d = wstrb;
            wdata_d = wdata;
            cnt_d   = 3'(LATENCY);
        end
        if (state_q == WAIT && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
        if (access) begin
            ready_d    = 1'b1;
            addr_err_d = !legal;
            rdata_d    = legal ? old_word : 32'h0;
        end
    end

    // Byte-strobed RAM write; reset on the same edge suppresses it
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // Output decode
    always_comb begin
        busy     = (state_q != IDLE);
        ready    = ready_q;
        addr_err = addr_err_q;
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 0, 1 and 3.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [3:0]  wstrb [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  ready;
    logic [2:0]  addr_err;
    logic [2:0]  busy;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k=0: LATENCY 0, k=1: LATENCY 1, k=2: LATENCY 3
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wstrb(wstrb[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
        .addr_err(addr_err[0]), .busy(busy[0]));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wstrb(wstrb[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
        .addr_err(addr_err[1]), .busy(busy[1]));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wstrb(wstrb[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]),
        .addr_err(addr_err[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on instance k; checks latency, response and return to idle
    task automatic transact(input int k, input logic w, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d,
                            input logic chk_rd, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_lat, input string tag);
        int cyc;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wstrb[k] = s; wdata[k] = d;
        @(posedge clk); #1;
        req[k] = 1'b0;
        chk({tag, ".busy_acc"}, 32'(busy[k]), 32'd1);
        cyc = 0;
        while (!ready[k] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".ready"}, 32'(ready[k]), 32'd1);
        chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".err"}, 32'(addr_err[k]), 32'(exp_err));
        if (chk_rd) chk({tag, ".rdata"}, rdata[k], exp_rd);
        @(posedge clk); #1;
        chk({tag, ".ready_off"}, 32'(ready[k]), 32'd0);
        chk({tag, ".busy_off"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        logic [31:0] rd1;
        logic [31:0] rd2;

        rst = '1; req = '0; we = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; wstrb[k] = '0; wdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d.ready", k), 32'(ready[k]), 32'd0);
            chk($sformatf("rst%0d.err", k), 32'(addr_err[k]), 32'd0);
            chk($sformatf("rst%0d.busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst%0d.rdata", k), rdata[k], 32'h0);
        end
        @(negedge clk);
        rst = '0;

        // LATENCY=1 write then read back
        transact(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, "l1_wr10");
        transact(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, "l1_rd10");

        // Byte strobes with read-before-write
        transact(1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, 2, "bs_init");
        transact(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0, 2, "bs_wr");
        transact(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'h11BB33DD, 1'b0, 2, "bs_rd");

        // Illegal addresses (0x1000 would alias to word 0 if range check were missing)
        transact(1, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 2, "il_init");
        transact(1, 1'b0, 32'h22, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, 2, "il_rd22");
        transact(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 2, "il_wr1000");
        transact(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 2, "il_rd0");

        // req held high across two reads; second accepted on first IDLE edge
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; wstrb[1] = 4'h0;
        @(posedge clk); #1;
        addr[1] = 32'h20;
        pulses = 0; first_at = -1; second_at = -1; rd1 = '0; rd2 = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (ready[1]) begin
                pulses++;
                if (pulses == 1) begin first_at = c; rd1 = rdata[1]; end
                if (pulses == 2) begin second_at = c; rd2 = rdata[1]; req[1] = 1'b0; end
            end
        end
        req[1] = 1'b0;
        chk("hold.pulses", 32'(pulses), 32'd2);
        chk("hold.first_at", 32'(first_at), 32'd2);
        chk("hold.second_at", 32'(second_at), 32'd6);
        chk("hold.rd1", rd1, 32'hDEADBEEF);
        chk("hold.rd2", rd2, 32'h11BB33DD);

        // LATENCY=3: reset during second WAIT cycle aborts the write
        transact(2, 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b0, 32'h0, 1'b0, 4, "l3_init");
        transact(2, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 4, "l3_rd");
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wstrb[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        chk("rmid.busy_wait2", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        chk("rmid.busy", 32'(busy[2]), 32'd0);
        chk("rmid.ready", 32'(ready[2]), 32'd0);
        chk("rmid.rdata", rdata[2], 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready[2]) pulses++;
        end
        chk("rmid.no_ready", 32'(pulses), 32'd0);
        transact(2, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 4, "rmid_rd");

        // LATENCY=0 sequence of accesses
        transact(0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b0, 1, "l0_wr0");
        transact(0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b0, 32'h0, 1'b0, 1, "l0_wr4");
        transact(0, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1'b0, 32'h0, 1'b0, 1, "l0_wr8");
        transact(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hA0A0A0A0, 1'b0, 1, "l0_rd0");
        transact(0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1, 32'hB1B1B1B1, 1'b0, 1, "l0_rd4");
        transact(0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'hC2C2C2C2, 1'b0, 1, "l0_rd8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
